hls_shared_div_sched: RTL and testbench
=======================================

Name: hls_shared_div_sched

Overview:
- Scheduler/arbiter that shares one iterative signed divider among NREQ scheduled-datapath FSMs.
- Replaces the per-state "/" operators in our HLS-generated state machines with a single divider resource.
- Each requester issues a request with operands, receives a one-cycle grant, then a one-cycle done with quotient/remainder.
- Round-robin fairness; one division in flight at a time.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/result width in bits (signed two's complement)

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  asynchronous active-low reset (0 = reset)
req  in  NREQ  per-requester request, level
op_a  in  NREQ*W  dividends, requester i at [i*W +: W]
op_b  in  NREQ*W  divisors, requester i at [i*W +: W]
gnt  out  NREQ  one-hot grant pulse, operands sampled
done  out  NREQ  one-hot completion pulse to the owning requester
q_out  out  W  signed quotient, valid while done != 0, held after
r_out  out  W  signed remainder, valid while done != 0, held after
div0  out  1  divisor was zero, valid with done
busy  out  1  high in CALC and DONE states

Behaviour:
- Reset (Rst=0, async): state=IDLE, ptr=0, gnt=0, done=0, q_out=0, r_out=0, div0=0, busy=0. Reset mid-operation aborts the division; no done is issued.
- States: IDLE, CALC, DONE.
- IDLE:
  - done and gnt are 0 except for pulses described below.
  - If any req=1 at the edge, choose the winner by round-robin: first asserted index scanning ptr, ptr+1, ... mod NREQ.
  - On that edge: latch |a|, |b|, sign(q)=sa^sb, sign(r)=sa, and owner; set gnt[owner]=1 for exactly one cycle; ptr<=(owner+1) mod NREQ; cnt<=0; go to CALC.
  - If no req, remain in IDLE.
- CALC: one restoring shift/subtract step per cycle on unsigned magnitudes; exactly W cycles; cnt counts 0..W-1; go to DONE after step W-1.
- DONE (one edge):
  - Apply signs and register q_out, r_out, div0.
  - done[owner]=1 for one cycle; go to IDLE.
- Latency: done rises exactly W+1 cycles after gnt rises. Back-to-back throughput is one operation per W+2 cycles, because the IDLE edge that sees done high may grant again.
- Handshake:
  - Requester holds req and operands until it sees gnt.
  - Operands may change after gnt.
  - req high in IDLE after done counts as a new request.
  - req dropped before grant is simply not served.
  - req changes by the owner during CALC are ignored.
- Arithmetic: truncation toward zero, matching Verilog signed "/" and "%"; the remainder takes the dividend's sign; magnitudes are held as W-bit unsigned, so -2^(W-1) is legal.
- Overflow: (-2^(W-1)) / (-1) wraps to q=-2^(W-1), r=0.
- Divide by zero: q=0, r=op_a, div0=1; same latency and handshake.
- q_out, r_out and div0 hold their last values until the next DONE.

Test Plan:
1. Reset, then req[0]=1, a=100, b=7 -> gnt=4'b0001 for one cycle; 17 cycles later done=4'b0001, q_out=14, r_out=2, div0=0; busy high for 17 cycles.
2. Signed cases on req[1]:
   - -100/7 -> q=-14, r=-2
   - 100/-7 -> q=-14, r=2
   - -100/-7 -> q=14, r=-2
3. Divide by zero: req[2], a=55, b=0 -> done[2] after 17 cycles, q=0, r=55, div0=1. Next op 9/3 -> q=3, r=0, div0=0.
4. Arbitration:
   - After reset, all four req held with requesters dropping req after their gnt -> grants in order 0,1,2,3, spaced 18 cycles apart.
   - Then req[3] and req[0] asserted together -> gnt[0] first, since ptr=0 after owner 3.
5. Overflow: -32768 / -1 -> q=-32768, r=0. Also 32767 / 1 -> q=32767, r=0.
6. Reset mid-operation: Rst=0 for one cycle at CALC cnt=8 -> all outputs 0 immediately (asynchronous), no done pulse. Then req[2] with 20/6 -> gnt[2] (ptr=0 path), q=3, r=2.

Source files
------------

// File: rtl/hls_shared_div_sched.sv
// hls_shared_div_sched: one iterative signed divider shared by NREQ requesters.
// Round-robin grant in IDLE, W restoring steps in CALC, sign fix-up and a
// one-cycle done pulse in DONE. Only one division is in flight at a time.
module hls_shared_div_sched #(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      q_out,
    output logic [W-1:0]      r_out,
    output logic              div0,
    output logic              busy
);

    localparam int          PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW     = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [NREQ-1:0] done_nxt;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   cnt;

    // Divider datapath registers (unsigned magnitudes plus result signs)
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W-1:0]    quo;
    logic [W-1:0]    rem;
    logic            sign_q;
    logic            sign_r;
    logic            b_zero;

    // Arbiter results
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    int unsigned     scan_idx;

    // Winner operands and their magnitudes
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W-1:0]    a_sel_mag;
    logic [W-1:0]    b_sel_mag;

    // One restoring step
    logic [W:0]      trial;
    logic [W:0]      diff;
    logic            step_bit;
    logic [W-1:0]    step_rem;

    // Final signed results
    logic [W-1:0]    q_fin;
    logic [W-1:0]    r_fin;

    // Round-robin scan starting at ptr, wrapping modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            scan_idx = 32'(ptr) + i;
            if (scan_idx >= NREQ_U) begin
                scan_idx = scan_idx - NREQ_U;
            end
            cand = PW'(scan_idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's operands and take unsigned magnitudes
    always_comb begin
        a_sel     = op_a[int'(win_idx)*W +: W];
        b_sel     = op_b[int'(win_idx)*W +: W];
        a_sel_mag = a_sel[W-1] ? ('0 - a_sel) : a_sel;
        b_sel_mag = b_sel[W-1] ? ('0 - b_sel) : b_sel;
    end

    // Restoring shift/subtract step; quo holds the remaining dividend bits
    always_comb begin
        trial    = {rem, quo[W-1]};
        diff     = trial - {1'b0, b_mag};
        step_bit = ~diff[W];
        step_rem = step_bit ? diff[W-1:0] : trial[W-1:0];
    end

    // Sign fix-up; divide by zero returns q=0 and r=dividend
    always_comb begin
        q_fin = '0;
        r_fin = sign_r ? ('0 - a_mag) : a_mag;
        if (!b_zero) begin
            q_fin = sign_q ? ('0 - quo) : quo;
            r_fin = sign_r ? ('0 - rem) : rem;
        end
    end

    // Next-state and pulse decode
    always_comb begin
        state_nxt = state;
        gnt_nxt   = '0;
        done_nxt  = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt        = CALC;
                    gnt_nxt[win_idx] = 1'b1;
                end
            end
            CALC: begin
                if (cnt == CW'(W - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt      = IDLE;
                done_nxt[owner] = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and registered handshake pulses
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Divider datapath, pointer and result registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            quo    <= '0;
            rem    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            b_zero <= 1'b0;
            q_out  <= '0;
            r_out  <= '0;
            div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner  <= win_idx;
                        ptr    <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                        cnt    <= '0;
                        a_mag  <= a_sel_mag;
                        b_mag  <= b_sel_mag;
                        quo    <= a_sel_mag;
                        rem    <= '0;
                        sign_q <= a_sel[W-1] ^ b_sel[W-1];
                        sign_r <= a_sel[W-1];
                        b_zero <= (b_sel == '0);
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= {quo[W-2:0], step_bit};
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    q_out <= q_fin;
                    r_out <= r_fin;
                    div0  <= b_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_shared_div_sched.sv
// Directed bench for hls_shared_div_sched: table of single-requester divisions,
// then arbitration order/spacing, and an asynchronous reset during CALC.
module tb_hls_shared_div_sched;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              Clk;
    logic              Rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      q_out;
    logic [W-1:0]      r_out;
    logic              div0;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    hls_shared_div_sched #(.NREQ(NREQ), .W(W)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .req  (req),
        .op_a (op_a),
        .op_b (op_b),
        .gnt  (gnt),
        .done (done),
        .q_out(q_out),
        .r_out(r_out),
        .div0 (div0),
        .busy (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        d0;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Called at a negedge: issue one request and check grant, latency and results
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ed0);
        int lat;
        int bcnt;
        req[idx] = 1'b1;
        op_a[idx*W +: W] = a;
        op_b[idx*W +: W] = b;
        @(negedge Clk);
        check("gnt", 32'(gnt), 32'(1) << idx);
        bcnt = busy ? 1 : 0;
        req[idx] = 1'b0;
        op_a[idx*W +: W] = 16'h7bcd;
        op_b[idx*W +: W] = 16'h0003;
        lat = 0;
        while (lat < 40) begin
            @(negedge Clk);
            lat++;
            if (lat == 1) check("gnt_pulse", 32'(gnt), 32'd0);
            if (done != '0) break;
            if (busy) bcnt++;
        end
        check("latency", 32'(lat), 32'd17);
        check("done", 32'(done), 32'(1) << idx);
        check("q_out", 32'(q_out), 32'(eq));
        check("r_out", 32'(r_out), 32'(er));
        check("div0", 32'(div0), 32'(ed0));
        check("busy_cycles", 32'(bcnt), 32'd17);
        @(negedge Clk);
        check("done_pulse", 32'(done), 32'd0);
        check("q_hold", 32'(q_out), 32'(eq));
    endtask

    initial begin
        int t;
        int last;
        logic [15:0] arb_a[4];
        logic [15:0] arb_b[4];
        logic [15:0] arb_q[4];
        logic [15:0] arb_r[4];

        //         idx  a          b          q          r          d0
        tbl[0]  = '{0, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
        tbl[1]  = '{1, -16'sd100, 16'd7,     -16'sd14,  -16'sd2,   1'b0};
        tbl[2]  = '{1, 16'd100,   -16'sd7,   -16'sd14,  16'd2,     1'b0};
        tbl[3]  = '{1, -16'sd100, -16'sd7,   16'd14,    -16'sd2,   1'b0};
        tbl[4]  = '{2, 16'd55,    16'd0,     16'd0,     16'd55,    1'b1};
        tbl[5]  = '{2, 16'd9,     16'd3,     16'd3,     16'd0,     1'b0};
        tbl[6]  = '{0, 16'h8000,  16'hffff,  16'h8000,  16'd0,     1'b0};
        tbl[7]  = '{0, 16'd32767, 16'd1,     16'd32767, 16'd0,     1'b0};
        tbl[8]  = '{3, -16'sd7,   16'd2,     -16'sd3,   -16'sd1,   1'b0};
        tbl[9]  = '{1, 16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
        tbl[10] = '{2, -16'sd55,  16'd0,     16'd0,     -16'sd55,  1'b1};
        tbl[11] = '{3, 16'h8000,  16'd3,     -16'sd10922, -16'sd2, 1'b0};

        arb_a = '{16'd50, 16'd51, 16'd52, 16'd53};
        arb_b = '{16'd2,  16'd3,  16'd4,  16'd5};
        arb_q = '{16'd25, 16'd17, 16'd13, 16'd10};
        arb_r = '{16'd0,  16'd0,  16'd0,  16'd3};

        Rst  = 1'b0;
        req  = '0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(negedge Clk);
        check("rst_gnt",  32'(gnt),   32'd0);
        check("rst_done", 32'(done),  32'd0);
        check("rst_q",    32'(q_out), 32'd0);
        check("rst_r",    32'(r_out), 32'd0);
        check("rst_div0", 32'(div0),  32'd0);
        check("rst_busy", 32'(busy),  32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].d0);
        end

        // Arbitration: fresh reset so ptr=0, all four request together
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op_a[k*W +: W] = arb_a[k];
            op_b[k*W +: W] = arb_b[k];
        end
        req  = 4'b1111;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (gnt == '0 && t < 60) begin
                @(negedge Clk);
                t++;
            end
            check("arb_gnt", 32'(gnt), 32'(1) << k);
            if (k > 0) check("arb_spacing", 32'(cyc - last), 32'd18);
            last   = cyc;
            req[k] = 1'b0;
            t = 0;
            while (done == '0 && t < 40) begin
                @(negedge Clk);
                t++;
            end
            check("arb_done", 32'(done), 32'(1) << k);
            check("arb_q", 32'(q_out), 32'(arb_q[k]));
            check("arb_r", 32'(r_out), 32'(arb_r[k]));
        end

        // ptr wrapped to 0 after owner 3: req[0] beats req[3]
        op_a[0*W +: W] = 16'd40;
        op_b[0*W +: W] = 16'd5;
        op_a[3*W +: W] = -16'sd9;
        op_b[3*W +: W] = 16'd4;
        req = 4'b1001;
        t = 0;
        while (gnt == '0 && t < 60) begin
            @(negedge Clk);
            t++;
        end
        check("wrap_gnt0", 32'(gnt), 32'd1);
        req[0] = 1'b0;
        t = 0;
        while (done == '0 && t < 40) begin
            @(negedge Clk);
            t++;
        end
        check("wrap_q0", 32'(q_out), 32'd8);
        check("wrap_r0", 32'(r_out), 32'd0);
        t = 0;
        while (gnt == '0 && t < 60) begin
            @(negedge Clk);
            t++;
        end
        check("wrap_gnt3", 32'(gnt), 32'b1000);
        req[3] = 1'b0;
        t = 0;
        while (done == '0 && t < 40) begin
            @(negedge Clk);
            t++;
        end
        check("wrap_q3", 32'(q_out), 32'(16'hfffe));
        check("wrap_r3", 32'(r_out), 32'(16'hffff));
        @(negedge Clk);

        // Asynchronous reset while CALC is at cnt=8
        req[1] = 1'b1;
        op_a[1*W +: W] = 16'd1000;
        op_b[1*W +: W] = 16'd3;
        @(negedge Clk);
        check("mid_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        repeat (8) @(negedge Clk);
        check("mid_busy", 32'(busy), 32'd1);
        Rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy),  32'd0);
        check("mid_rst_q",    32'(q_out), 32'd0);
        check("mid_rst_r",    32'(r_out), 32'd0);
        check("mid_rst_div0", 32'(div0),  32'd0);
        check("mid_rst_gd",   32'({gnt, done}), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        t = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (done != '0 || busy) t++;
        end
        check("mid_no_done", 32'(t), 32'd0);
        run_op(2, 16'd20, 16'd6, 16'd3, 16'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
